// File: rtl/bus_arbiter.sv
// Two-master (CPU m0, DMA m1) arbiter onto one shared memory port, with a per-transfer timeout.
// Define ROUND_ROBIN_EN for alternating grants on contention; otherwise m0 has fixed priority.
module bus_arbiter #(
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_err,
  output logic        s_req,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic [1:0]  gnt
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout;
  logic       win1;

`ifdef ROUND_ROBIN_EN
  logic last_q, last_d;  // 1 = m1 held the most recent grant

  always_comb begin
    win1   = m1_req && (!m0_req || !last_q);
    last_d = last_q;
    if (state_q != IDLE && (s_ready || timeout))
      last_d = (state_q == GNT1);
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  always_comb win1 = m1_req && !m0_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Timeout fires on the TMO_CYCLES-th grant cycle; s_ready in that cycle takes precedence.
  assign timeout = (cnt_q == TMO_LAST) && !s_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m0_ready = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = '0;
    s_req    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_wdata  = '0;
    gnt      = state_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (win1)        state_d = GNT1;
        else if (m0_req) state_d = GNT0;
      end
      GNT0: begin
        s_req   = 1'b1;
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_wdata = m0_wdata;
        if (s_ready) begin
          m0_ready = 1'b1;
          m0_rdata = s_rdata;
          state_d  = IDLE;
        end else if (timeout) begin
          m0_err  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GNT1: begin
        s_req   = 1'b1;
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_wdata = m1_wdata;
        if (s_ready) begin
          m1_ready = 1'b1;
          m1_rdata = s_rdata;
          state_d  = IDLE;
        end else if (timeout) begin
          m1_err  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
